pipelined_addsub: RTL and testbench



---
 rtl/addsub_pkg.sv | 24 ++
 rtl/addsub_stage.sv | 42 ++++
 rtl/pipelined_addsub.sv | 148 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   addsub_op_e  : per-transaction operation encoding (op_sub input)
//   sat_max/min  : signed saturation limits for a given width (width <= 64)
//   stage_w_ok   : true when a width splits evenly into stage chunks
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic bit stage_w_ok(input int unsigned width, input int unsigned stage_w);
    return (stage_w != 0) && ((width % stage_w) == 0);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One registered STAGE_W-bit chunk of the carry-chained adder.
//   clk, rst_n    : clock, synchronous active-low reset
//   en            : pipeline advance; registers hold when low
//   a, b, cin     : chunk operands and carry from the previous chunk
//   sum, cout     : registered chunk sum and carry out
//   a_msb, b_msb  : registered operand sign taps (used by the MSB chunk)
module addsub_stage #(
  parameter int unsigned STAGE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [STAGE_W-1:0] a,
  input  logic [STAGE_W-1:0] b,
  input  logic               cin,
  output logic [STAGE_W-1:0] sum,
  output logic               cout,
  output logic               a_msb,
  output logic               b_msb
);

  logic [STAGE_W:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{STAGE_W{1'b0}}, cin};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum   <= '0;
      cout  <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (en) begin
      sum   <= total[STAGE_W-1:0];
      cout  <= total[STAGE_W];
      a_msb <= a[STAGE_W-1];
      b_msb <= b[STAGE_W-1];
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with optional signed
// saturation and a valid/ready handshake. Latency is STAGES cycles.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid, in_ready   : operand handshake
//   a, b, cin            : operands and carry/borrow in
//   op_sub, sat_en       : per-transaction mode bits
//   out_valid, out_ready : result handshake
//   sum, cout, overflow  : result, raw adder carry, unsaturated signed overflow
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned STAGE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned STAGES = WIDTH / STAGE_W;
  localparam int unsigned LAST   = STAGES - 1;
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  if (!stage_w_ok(WIDTH, STAGE_W)) begin : g_bad_stage_w
    $error("pipelined_addsub: WIDTH must be a multiple of STAGE_W");
  end

  logic             adv;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c0;

  // Per-slot state; index k is the register set loaded by stage k.
  logic             v_q    [STAGES];
  logic             sat_q  [STAGES];
  logic [WIDTH-1:0] a_skew [STAGES];
  logic [WIDTH-1:0] b_skew [STAGES];
  logic [WIDTH-1:0] dsk_q  [STAGES];  // chunks 0..k-1 already resolved
  logic [STAGE_W-1:0] s_q  [STAGES];
  logic             c_q    [STAGES];
  logic             am_q   [STAGES];
  logic             bm_q   [STAGES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    a_in = a;
    b_in = (op_sub == OP_SUB) ? ~b : b;
    c0   = (op_sub == OP_SUB) ? ~cin : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [STAGE_W-1:0] st_a;
    logic [STAGE_W-1:0] st_b;
    logic               st_c;
    logic               v_d;
    logic               sat_d;
    logic [WIDTH-1:0]   as_d;
    logic [WIDTH-1:0]   bs_d;
    logic [WIDTH-1:0]   dsk_d;

    if (k == 0) begin : g_first
      always_comb begin
        st_a  = a_in[STAGE_W-1:0];
        st_b  = b_in[STAGE_W-1:0];
        st_c  = c0;
        v_d   = in_valid;
        sat_d = sat_en;
        as_d  = a_in;
        bs_d  = b_in;
        dsk_d = '0;
      end
    end else begin : g_rest
      always_comb begin
        st_a  = a_skew[k-1][k*STAGE_W +: STAGE_W];
        st_b  = b_skew[k-1][k*STAGE_W +: STAGE_W];
        st_c  = c_q[k-1];
        v_d   = v_q[k-1];
        sat_d = sat_q[k-1];
        as_d  = a_skew[k-1];
        bs_d  = b_skew[k-1];
        dsk_d = dsk_q[k-1];
        dsk_d[(k-1)*STAGE_W +: STAGE_W] = s_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q[k]    <= 1'b0;
        sat_q[k]  <= 1'b0;
        a_skew[k] <= '0;
        b_skew[k] <= '0;
        dsk_q[k]  <= '0;
      end else if (adv) begin
        v_q[k]    <= v_d;
        sat_q[k]  <= sat_d;
        a_skew[k] <= as_d;
        b_skew[k] <= bs_d;
        dsk_q[k]  <= dsk_d;
      end
    end

    addsub_stage #(.STAGE_W(STAGE_W)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .a     (st_a),
      .b     (st_b),
      .cin   (st_c),
      .sum   (s_q[k]),
      .cout  (c_q[k]),
      .a_msb (am_q[k]),
      .b_msb (bm_q[k])
    );
  end

  logic [WIDTH-1:0] raw_sum;

  // Overflow and saturation are decoded from the last slot's registers, so
  // the outputs depend only on flops and stay stable across a stall.
  always_comb begin
    raw_sum = dsk_q[LAST];
    raw_sum[LAST*STAGE_W +: STAGE_W] = s_q[LAST];
    overflow = (am_q[LAST] == bm_q[LAST]) && (raw_sum[WIDTH-1] != am_q[LAST]);
    if (sat_q[LAST] && overflow) begin
      sum = am_q[LAST] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = raw_sum;
    end
  end

  assign cout      = c_q[LAST];
  assign out_valid = v_q[LAST];

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        op_sub;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .STAGE_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  vec_t vecs [12];

  logic [15:0] sa   [16];
  logic [15:0] sb   [16];
  logic        scin [16];
  logic        ssub [16];
  logic        ssat [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on the signed/unsigned operand values.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub, input logic msat);
    int sva, svb, ua, ub, ci, r;
    logic        mc, mo;
    logic [15:0] ms;
    sva = $signed(ma);
    svb = $signed(mb);
    ua  = ma;
    ub  = mb;
    ci  = mcin;
    if (msub) begin
      r  = sva - svb - ci;
      mc = (ua >= ub + ci);
    end else begin
      r  = sva + svb + ci;
      mc = (ua + ub + ci) > 65535;
    end
    mo = (r > 32767) || (r < -32768);
    ms = r[15:0];
    if (msat && mo) ms = (r > 0) ? 16'h7FFF : 16'h8000;
    return {mo, mc, ms};
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; sat_en = 1'b0;
  endtask

  // One transaction into an empty pipe; checks latency, result and the
  // out_valid drop on the following cycle.
  task automatic run_vec(input int idx);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = vecs[idx].a; b = vecs[idx].b; cin = vecs[idx].cin;
    op_sub = vecs[idx].sub; sat_en = vecs[idx].sat;
    n = 0;
    do begin
      @(posedge clk); #1;
      idle_inputs();
      n++;
    end while (!out_valid && n < 10);
    chk($sformatf("vec%0d_latency", idx), n, 4);
    chk($sformatf("vec%0d_sum", idx), sum, vecs[idx].esum);
    chk($sformatf("vec%0d_cout", idx), cout, vecs[idx].ecout);
    chk($sformatf("vec%0d_ovf", idx), overflow, vecs[idx].eovf);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_valid_drop", idx), out_valid, 1'b0);
  endtask

  // Drives n queued transactions while scoring results in order; out_ready
  // is dropped for stall_len cycles starting at cycle stall_at.
  task automatic run_stream(input int n, input int stall_at, input int stall_len, input bit timing);
    logic [17:0] exp_q [$];
    logic [17:0] e;
    logic [15:0] held;
    bit          held_v;
    int          sent, got, cyc, first, last;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1; held_v = 0; held = '0;
    while ((sent < n || got < n) && cyc < 200) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (sent < n) begin
        in_valid = 1'b1;
        a = sa[sent]; b = sb[sent]; cin = scin[sent]; op_sub = ssub[sent]; sat_en = ssat[sent];
      end else begin
        idle_inputs();
      end
      #1;
      if (out_valid && held_v) chk("stall_sum_hold", sum, held);
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 1'b0);
        held   = sum;
        held_v = 1;
      end else begin
        held_v = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_result", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream_sum%0d", got), sum, e[15:0]);
          chk($sformatf("stream_cout%0d", got), cout, e[16]);
          chk($sformatf("stream_ovf%0d", got), overflow, e[17]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, op_sub, sat_en));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_timeout", (cyc < 200), 1'b1);
    chk("stream_count", got, n);
    chk("stream_leftover", exp_q.size(), 0);
    if (timing) begin
      chk("stream_first_cycle", first, 4);
      chk("stream_last_cycle", last, n + 3);
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("stream_no_dup", out_valid, 1'b0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      sa[i]   = 16'($urandom);
      sb[i]   = 16'($urandom);
      scin[i] = 1'($urandom);
      ssub[i] = 1'($urandom);
      ssat[i] = 1'($urandom);
    end
  endtask

  initial begin
    int stale;
    //          a        b        cin   sub   sat   sum      cout  ovf
    vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[3]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
    vecs[5]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[6]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[8]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
    vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[11] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};

    rst_n = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(i);

    fill_random(8);
    run_stream(8, 1000, 0, 1'b1);

    fill_random(12);
    run_stream(12, 6, 6, 1'b0);

    // Reset with three transactions in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'h7FF0 + 16'(i); b = 16'h1234; cin = 1'b1; op_sub = 1'b0; sat_en = 1'b0;
      @(posedge clk); #1;
    end
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sum", sum, 16'h0000);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("midrst_no_stale", stale, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
